// File: rtl/noc_packetizer.sv
// Serialises one coherence message into NoC flits: header, address, then optional line data.
// Optional feature macro: NOC_PACKETIZER_PARITY_EN adds the flit_parity output.
module noc_packetizer #(
  parameter int          CACHE_OFFSET_BITS = 2,
  parameter int          DATA_WIDTH        = 32,
  parameter int          ADDRESS_BITS      = 32,
  parameter int          MSG_BITS          = 4,
  parameter int          ID_BITS           = 3,
  parameter int          SRC_ID            = 0,
  parameter int          FLIT_WIDTH        = 32,
  parameter logic [15:0] DATA_MSG_MASK     = 16'h0000,
  parameter int          CACHE_WIDTH       = DATA_WIDTH << CACHE_OFFSET_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     msg_in,
  input  logic [ADDRESS_BITS-1:0] address_in,
  input  logic [CACHE_WIDTH-1:0]  data_in,
  input  logic [ID_BITS-1:0]      dest_id_in,
  output logic                    busy,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_valid,
  output logic                    flit_head,
  output logic                    flit_tail,
  input  logic                    flit_ready
`ifdef NOC_PACKETIZER_PARITY_EN
  ,
  output logic                    flit_parity
`endif
);

  localparam int WORDS = CACHE_WIDTH / FLIT_WIDTH;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int HDR_W = 2 * ID_BITS + MSG_BITS + 4;

  localparam logic [3:0]         LEN_DATA = 4'(WORDS + 1);
  localparam logic [3:0]         LEN_NONE = 4'd1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [ID_BITS-1:0] SRC_BITS = ID_BITS'(SRC_ID);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEAD = 2'd1;
  localparam logic [1:0] ADDR = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    has_data_reg, has_data_next;
  logic [ADDRESS_BITS-1:0] address_reg, address_next;
  logic [CACHE_WIDTH-1:0]  data_reg, data_next;
  logic [FLIT_WIDTH-1:0]   flit_next;
  logic                    valid_next, head_next, tail_next;

  logic                    has_data_in;
  logic [3:0]              len_in;
  logic [HDR_W-1:0]        hdr_bits;
  logic [CNT_W-1:0]        cnt_inc;

  // Line data split into flit-sized slices, least-significant slice first.
  logic [FLIT_WIDTH-1:0] slice [WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign slice[gi] = data_reg[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

  assign has_data_in = DATA_MSG_MASK[msg_in];
  assign len_in      = has_data_in ? LEN_DATA : LEN_NONE;
  assign hdr_bits    = {dest_id_in, SRC_BITS, msg_in, len_in};
  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign busy        = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    has_data_next = has_data_reg;
    address_next  = address_reg;
    data_next     = data_reg;
    flit_next     = flit_out;
    valid_next    = flit_valid;
    head_next     = flit_head;
    tail_next     = flit_tail;

    case (state_reg)
      IDLE: begin
        if (msg_in != '0) begin
          state_next    = HEAD;
          has_data_next = has_data_in;
          address_next  = address_in;
          data_next     = data_in;
          flit_next     = FLIT_WIDTH'(hdr_bits) << (FLIT_WIDTH - HDR_W);
          valid_next    = 1'b1;
          head_next     = 1'b1;
          tail_next     = 1'b0;
        end
      end
      HEAD: begin
        if (flit_ready) begin
          state_next = ADDR;
          flit_next  = FLIT_WIDTH'(address_reg);
          head_next  = 1'b0;
          tail_next  = !has_data_reg;
        end
      end
      ADDR: begin
        if (flit_ready) begin
          if (has_data_reg) begin
            state_next = DATA;
            cnt_next   = '0;
            flit_next  = slice[0];
            tail_next  = (WORDS == 1);
          end else begin
            state_next = IDLE;
            flit_next  = '0;
            valid_next = 1'b0;
            tail_next  = 1'b0;
          end
        end
      end
      default: begin
        if (flit_ready) begin
          if (cnt_reg == LAST_CNT) begin
            state_next = IDLE;
            cnt_next   = '0;
            flit_next  = '0;
            valid_next = 1'b0;
            tail_next  = 1'b0;
          end else begin
            cnt_next  = cnt_inc;
            flit_next = slice[cnt_inc];
            tail_next = (cnt_inc == LAST_CNT);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      has_data_reg <= 1'b0;
      address_reg  <= '0;
      data_reg     <= '0;
      flit_out     <= '0;
      flit_valid   <= 1'b0;
      flit_head    <= 1'b0;
      flit_tail    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      has_data_reg <= has_data_next;
      address_reg  <= address_next;
      data_reg     <= data_next;
      flit_out     <= flit_next;
      flit_valid   <= valid_next;
      flit_head    <= head_next;
      flit_tail    <= tail_next;
    end
  end

`ifdef NOC_PACKETIZER_PARITY_EN
  // Parity travels with the flit so it is always coherent with flit_out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flit_parity <= 1'b0;
    end else begin
      flit_parity <= valid_next ? ^{head_next, tail_next, flit_next} : 1'b0;
    end
  end
`endif

endmodule
